// File: rtl/iu_pred_sched.sv
`default_nettype none
// ============================================================================
//  Module      : iu_pred_sched
//  Description : Shares one multi-cycle next-PC predictor (iu) between
//                N_HART fetch requesters. Redirect (miss) requests win over
//                normal ones, round-robin within each class. One job is in
//                flight at a time. A job whose predictor result does not
//                arrive within TIMEOUT cycles completes with pc+4.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                req/req_miss     - per-hart request level / redirect flag
//                req_pc/req_insn  - per-hart PC (64b) and instruction (32b)
//                gnt              - one-hot pulse, request accepted
//                rsp_valid        - one-hot pulse, result for that hart
//                rsp_pc           - predicted (or fallback) PC
//                rsp_timeout      - result is the pc+4 fallback
//                iu_*             - predictor request / result interface
//                busy             - scheduler is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module iu_pred_sched #(
    parameter int N_HART  = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_HART-1:0]     req,
    input  logic [N_HART-1:0]     req_miss,
    input  logic [64*N_HART-1:0]  req_pc,
    input  logic [32*N_HART-1:0]  req_insn,
    output logic [N_HART-1:0]     gnt,
    output logic [N_HART-1:0]     rsp_valid,
    output logic [63:0]           rsp_pc,
    output logic                  rsp_timeout,
    output logic                  iu_miss,
    output logic [63:0]           iu_pc_curr,
    output logic [31:0]           iu_insn_curr,
    input  logic [63:0]           iu_pc_pre,
    input  logic                  iu_pc_pre_oe,
    output logic                  busy
);

    localparam int c_IDX_W = $clog2(N_HART);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic [c_IDX_W-1:0]  r_win;
    logic [CNT_W-1:0]    r_cnt;

    logic [N_HART-1:0]   w_miss_req;
    logic [N_HART-1:0]   w_cand;
    logic [c_IDX_W-1:0]  w_win;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_found;

    // Winner search: restrict candidates to redirect requests when any are
    // present, then take the first candidate at or after r_rr_ptr, wrapping.
    always_comb begin
        w_miss_req = req & req_miss;
        w_cand     = (|w_miss_req) ? w_miss_req : req;
        w_win      = '0;
        w_idx      = '0;
        w_found    = 1'b0;
        for (int i = 0; i < N_HART; i++) begin
            w_idx = c_IDX_W'((int'(r_rr_ptr) + i) % N_HART);
            if (!w_found && w_cand[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_win        <= '0;
            r_cnt        <= '0;
            gnt          <= '0;
            rsp_valid    <= '0;
            rsp_pc       <= '0;
            rsp_timeout  <= 1'b0;
            iu_miss      <= 1'b0;
            iu_pc_curr   <= '0;
            iu_insn_curr <= '0;
            busy         <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for one state only.
            gnt       <= '0;
            rsp_valid <= '0;
            iu_miss   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_win        <= w_win;
                        gnt          <= N_HART'(1) << w_win;
                        iu_miss      <= req_miss[w_win];
                        // The iu request registers double as the job's
                        // latched pc/insn for the rest of the job.
                        iu_pc_curr   <= req_pc[64*int'(w_win) +: 64];
                        iu_insn_curr <= req_insn[32*int'(w_win) +: 32];
                        busy         <= 1'b1;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A predictor result arriving on the timeout cycle wins.
                    if (iu_pc_pre_oe) begin
                        rsp_pc      <= iu_pc_pre;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= N_HART'(1) << r_win;
                        r_state     <= ST_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_pc      <= iu_pc_curr + 64'd4;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= N_HART'(1) << r_win;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_rr_ptr <= (r_win == c_IDX_W'(N_HART - 1)) ? '0 : r_win + 1'b1;
                    busy     <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iu_pred_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iu_pred_sched
//  Description : Self-checking bench for iu_pred_sched. Expected responses
//                are queued when a job is set up and popped when the DUT
//                returns a response; the bench plays the predictor role.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iu_pred_sched;

    localparam int N  = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    req_miss;
    logic [64*N-1:0] req_pc;
    logic [32*N-1:0] req_insn;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [63:0]     rsp_pc;
    logic            rsp_timeout;
    logic            iu_miss;
    logic [63:0]     iu_pc_curr;
    logic [31:0]     iu_insn_curr;
    logic [63:0]     iu_pc_pre;
    logic            iu_pc_pre_oe;
    logic            busy;

    iu_pred_sched #(.N_HART(N), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_miss     (req_miss),
        .req_pc       (req_pc),
        .req_insn     (req_insn),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_pc       (rsp_pc),
        .rsp_timeout  (rsp_timeout),
        .iu_miss      (iu_miss),
        .iu_pc_curr   (iu_pc_curr),
        .iu_insn_curr (iu_insn_curr),
        .iu_pc_pre    (iu_pc_pre),
        .iu_pc_pre_oe (iu_pc_pre_oe),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [N-1:0] hart;
        logic [63:0]  pc;
        logic         to;
    } exp_t;

    exp_t sbq[$];

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iu_pc_pre_oe = 1'b0;
        req = '0;
        req_miss = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input int max, output logic [N-1:0] g, output int cyc);
        g = '0;
        cyc = 0;
        while (cyc < max) begin
            tick();
            cyc++;
            if (gnt != '0) begin
                g = gnt;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int max, output logic [N-1:0] v, output logic [63:0] p,
                            output logic t, output int cyc);
        v = '0;
        p = '0;
        t = 1'b0;
        cyc = 0;
        while (1) begin
            if (rsp_valid != '0) begin
                v = rsp_valid;
                p = rsp_pc;
                t = rsp_timeout;
                break;
            end
            if (cyc >= max) break;
            tick();
            cyc++;
        end
    endtask

    // Runs one job: waits for the grant, optionally drops the granted request,
    // then answers as the predictor after k WAIT cycles (k < 0: never answers).
    // Returns what was observed; the calling test does the comparisons.
    task automatic run_job(input int k, input logic [63:0] pre, input bit drop,
                           output logic [N-1:0] g, output logic [N-1:0] g_next,
                           output logic im, output logic im_next,
                           output logic [63:0] ipc, output logic [31:0] iin,
                           output logic [N-1:0] v, output logic [63:0] p, output logic t,
                           output int lat, output int gcyc);
        int c;
        wait_gnt(24, g, gcyc);
        im  = iu_miss;
        ipc = iu_pc_curr;
        iin = iu_insn_curr;
        if (drop) begin
            req      = req & ~g;
            req_miss = req_miss & ~g;
        end
        g_next = '0;
        im_next = 1'b0;
        v = '0;
        p = '0;
        t = 1'b0;
        lat = 0;
        if (g != '0) begin
            tick();
            g_next  = gnt;
            im_next = iu_miss;
            if (k >= 0) begin
                repeat (k) tick();
                iu_pc_pre    = pre;
                iu_pc_pre_oe = 1'b1;
                tick();
                iu_pc_pre_oe = 1'b0;
                wait_rsp(4, v, p, t, c);
                lat = k + 2 + c;
            end else begin
                wait_rsp(TO + 8, v, p, t, c);
                lat = 1 + c;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
        checks++; if (rsp_valid !== '0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if ({rsp_timeout, iu_miss, busy} !== 3'b000) begin failures++;
            $display("FAIL reset_flags got to/miss/busy=%b exp=000", {rsp_timeout, iu_miss, busy}); end
        checks++; if ({rsp_pc, iu_pc_curr, iu_insn_curr} !== '0) begin failures++;
            $display("FAIL reset_data got rsp_pc=%h pc_curr=%h insn=%h exp=0", rsp_pc, iu_pc_curr, iu_insn_curr); end
    endtask

    task automatic test_single();
        logic [N-1:0] g, gn, v; logic im, imn, t; logic [63:0] ipc, p; logic [31:0] iin;
        int lat, gc; exp_t e;
        req_pc[63:0]   = 64'h1000;
        req_insn[31:0] = 32'h0000_0013;
        req_miss = '0;
        req = 4'b0001;
        sbq.push_back('{hart: 4'b0001, pc: 64'h1004, to: 1'b0});
        run_job(7, 64'h1004, 1'b1, g, gn, im, imn, ipc, iin, v, p, t, lat, gc);
        checks++; if (g !== 4'b0001 || gc !== 1) begin failures++; $display("FAIL single_gnt got=%b after %0d exp=0001 after 1", g, gc); end
        checks++; if (gn !== '0) begin failures++; $display("FAIL single_gnt_pulse got=%b exp=0", gn); end
        checks++; if (im !== 1'b0) begin failures++; $display("FAIL single_iu_miss got=%b exp=0", im); end
        checks++; if (ipc !== 64'h1000 || iin !== 32'h13) begin failures++;
            $display("FAIL single_iu_req got pc=%h insn=%h exp pc=1000 insn=13", ipc, iin); end
        e = sbq.pop_front();
        checks++; if (v !== e.hart || p !== e.pc || t !== e.to) begin failures++;
            $display("FAIL single_rsp got v=%b pc=%h to=%b exp v=%b pc=%h to=%b", v, p, t, e.hart, e.pc, e.to); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL single_latency got=%0d exp=9", lat); end
        tick();
        checks++; if (busy !== 1'b0 || rsp_valid !== '0) begin failures++;
            $display("FAIL single_idle got busy=%b rsp_valid=%b exp 0 0", busy, rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g, gn, v; logic im, imn, t; logic [63:0] ipc, p; logic [31:0] iin;
        int lat, gc; exp_t e;
        logic [N-1:0] order [5];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        do_reset();
        for (int h = 0; h < N; h++) req_pc[64*h +: 64] = 64'h2000 + 64'(h) * 64'h100;
        req_miss = '0;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            sbq.push_back('{hart: order[i], pc: 64'h5000 + 64'(i), to: 1'b0});
            run_job(i, 64'h5000 + 64'(i), 1'b0, g, gn, im, imn, ipc, iin, v, p, t, lat, gc);
            checks++; if (g !== order[i]) begin failures++; $display("FAIL rr_gnt_%0d got=%b exp=%b", i, g, order[i]); end
            if (i > 0) begin
                checks++; if (gc !== 2) begin failures++; $display("FAIL rr_gap_%0d got=%0d exp=2", i, gc); end
            end
            e = sbq.pop_front();
            checks++; if (v !== e.hart || p !== e.pc || t !== e.to || lat !== i + 2) begin failures++;
                $display("FAIL rr_rsp_%0d got v=%b pc=%h to=%b lat=%0d exp v=%b pc=%h to=%b lat=%0d",
                         i, v, p, t, lat, e.hart, e.pc, e.to, i + 2); end
        end
        req = '0;
    endtask

    task automatic test_miss_priority();
        logic [N-1:0] g, gn, v; logic im, imn, t; logic [63:0] ipc, p; logic [31:0] iin;
        int lat, gc; exp_t e;
        do_reset();
        req = 4'b0111;
        req_miss = 4'b0100;
        sbq.push_back('{hart: 4'b0100, pc: 64'h6000, to: 1'b0});
        run_job(2, 64'h6000, 1'b1, g, gn, im, imn, ipc, iin, v, p, t, lat, gc);
        checks++; if (g !== 4'b0100) begin failures++; $display("FAIL miss_gnt got=%b exp=0100", g); end
        checks++; if (im !== 1'b1 || imn !== 1'b0) begin failures++;
            $display("FAIL miss_iu_miss got issue=%b next=%b exp 1 0", im, imn); end
        checks++; if (ipc !== 64'h2200) begin failures++; $display("FAIL miss_pc_curr got=%h exp=2200", ipc); end
        e = sbq.pop_front();
        checks++; if (v !== e.hart || p !== e.pc || t !== e.to) begin failures++;
            $display("FAIL miss_rsp got v=%b pc=%h exp v=%b pc=%h", v, p, e.hart, e.pc); end
        // Pointer now at hart 3, which is not requesting: hart 0 is next.
        sbq.push_back('{hart: 4'b0001, pc: 64'h6100, to: 1'b0});
        run_job(1, 64'h6100, 1'b1, g, gn, im, imn, ipc, iin, v, p, t, lat, gc);
        checks++; if (g !== 4'b0001 || im !== 1'b0) begin failures++;
            $display("FAIL miss_next_gnt got=%b miss=%b exp=0001 0", g, im); end
        e = sbq.pop_front();
        checks++; if (v !== e.hart || p !== e.pc) begin failures++;
            $display("FAIL miss_next_rsp got v=%b pc=%h exp v=%b pc=%h", v, p, e.hart, e.pc); end
        run_job(0, 64'h6200, 1'b1, g, gn, im, imn, ipc, iin, v, p, t, lat, gc);
        checks++; if (g !== 4'b0010 || v !== 4'b0010 || p !== 64'h6200) begin failures++;
            $display("FAIL miss_third got gnt=%b v=%b pc=%h exp 0010 0010 6200", g, v, p); end
        req = '0;
        req_miss = '0;
    endtask

    task automatic test_timeout_wrap();
        logic [N-1:0] g, gn, v; logic im, imn, t; logic [63:0] ipc, p; logic [31:0] iin;
        int lat, gc, extra; exp_t e;
        req_pc[127:64] = 64'hFFFF_FFFF_FFFF_FFFC;
        req = 4'b0010;
        sbq.push_back('{hart: 4'b0010, pc: 64'h0, to: 1'b1});
        run_job(-1, 64'h0, 1'b1, g, gn, im, imn, ipc, iin, v, p, t, lat, gc);
        checks++; if (g !== 4'b0010) begin failures++; $display("FAIL to_gnt got=%b exp=0010", g); end
        e = sbq.pop_front();
        checks++; if (v !== e.hart || p !== e.pc || t !== e.to) begin failures++;
            $display("FAIL to_rsp got v=%b pc=%h to=%b exp v=%b pc=%h to=%b", v, p, t, e.hart, e.pc, e.to); end
        checks++; if (lat !== TO + 1) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", lat, TO + 1); end
        repeat (3) tick();
        iu_pc_pre = 64'hDEAD_0000;
        iu_pc_pre_oe = 1'b1;
        tick();
        iu_pc_pre_oe = 1'b0;
        extra = 0;
        repeat (20) begin
            tick();
            if (rsp_valid != '0 || busy) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL to_late_oe got=%0d active cycles exp=0", extra); end
    endtask

    task automatic test_collision();
        logic [N-1:0] g, gn, v; logic im, imn, t; logic [63:0] ipc, p; logic [31:0] iin;
        int lat, gc; exp_t e;
        req_pc[191:128] = 64'h3000;
        req = 4'b0100;
        sbq.push_back('{hart: 4'b0100, pc: 64'hABC0, to: 1'b0});
        run_job(TO - 1, 64'hABC0, 1'b1, g, gn, im, imn, ipc, iin, v, p, t, lat, gc);
        e = sbq.pop_front();
        checks++; if (g !== 4'b0100 || v !== e.hart || p !== e.pc || t !== e.to) begin failures++;
            $display("FAIL collision_rsp got gnt=%b v=%b pc=%h to=%b exp v=%b pc=%h to=%b",
                     g, v, p, t, e.hart, e.pc, e.to); end
        checks++; if (lat !== TO + 1) begin failures++; $display("FAIL collision_latency got=%0d exp=%0d", lat, TO + 1); end
    endtask

    task automatic test_reset_mid_wait();
        logic [N-1:0] g, gn, v; logic im, imn, t; logic [63:0] ipc, p; logic [31:0] iin;
        int c, lat, gc, extra; exp_t e;
        req = 4'b1000;
        wait_gnt(24, g, c);
        req = '0;
        checks++; if (g !== 4'b1000) begin failures++; $display("FAIL rstw_gnt got=%b exp=1000", g); end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || rsp_valid !== '0 || gnt !== '0) begin failures++;
            $display("FAIL rstw_idle got busy=%b rsp_valid=%b gnt=%b exp 0", busy, rsp_valid, gnt); end
        iu_pc_pre = 64'hBAD0;
        iu_pc_pre_oe = 1'b1;
        tick();
        iu_pc_pre_oe = 1'b0;
        extra = 0;
        repeat (TO + 4) begin
            tick();
            if (rsp_valid != '0 || busy) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL rstw_dropped got=%0d active cycles exp=0", extra); end
        // Pointer was cleared by reset, so hart 0 wins with all requesting.
        req = 4'b1111;
        sbq.push_back('{hart: 4'b0001, pc: 64'h7770, to: 1'b0});
        run_job(2, 64'h7770, 1'b1, g, gn, im, imn, ipc, iin, v, p, t, lat, gc);
        req = '0;
        e = sbq.pop_front();
        checks++; if (g !== 4'b0001 || v !== e.hart || p !== e.pc || t !== e.to) begin failures++;
            $display("FAIL rstw_next got gnt=%b v=%b pc=%h to=%b exp gnt=0001 v=%b pc=%h to=%b",
                     g, v, p, t, e.hart, e.pc, e.to); end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        req_miss = '0;
        req_pc = '0;
        req_insn = '0;
        iu_pc_pre = '0;
        iu_pc_pre_oe = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_miss_priority();
        test_timeout_wrap();
        test_collision();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iu_pred_sched.md
Name: iu_pred_sched

Overview:
- Schedules and shares one multi-cycle branch/next-PC predictor (the iu prediction unit) between N_HART fetch requesters.
- Arbitrates requests: redirect (miss) requests first, round-robin within each class.
- Sequences the predictor through one prediction, routes the result back to the winning requester, and applies a timeout fallback of pc+4.
- Sits between the per-hart fetch front-ends and the single iu instance.

Parameters:
N_HART, 4, number of requesters (2..8)
TIMEOUT, 16, cycles in WAIT before fallback response (must be > predictor WORK_PERIOD+2)
CNT_W, 8, width of timeout counter

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
req  in  N_HART  per-hart prediction request, level, held until gnt
req_miss  in  N_HART  per-hart: request is a redirect after mispredict
req_pc  in  64*N_HART  per-hart current PC, hart i at bits [64i+63:64i]
req_insn  in  32*N_HART  per-hart current instruction
gnt  out  N_HART  one-hot, one-cycle pulse: request accepted
rsp_valid  out  N_HART  one-hot, one-cycle pulse: prediction returned
rsp_pc  out  64  predicted PC, valid with rsp_valid
rsp_timeout  out  1  with rsp_valid: result is fallback, not predictor output
iu_miss  out  1  to predictor miss
iu_pc_curr  out  64  to predictor pc_curr
iu_insn_curr  out  32  to predictor insn_curr
iu_pc_pre  in  64  from predictor pc_pre
iu_pc_pre_oe  in  1  from predictor pc_pre_oe
busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE; rr_ptr=0; cnt=0.
  - gnt, rsp_valid, rsp_timeout, iu_miss, busy are 0.
  - rsp_pc, iu_pc_curr, iu_insn_curr are 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, select the winner w.
    - If any req&req_miss bit is set, w is the first such bit at or after rr_ptr, in circular order.
    - Otherwise w is the first req bit at or after rr_ptr.
  - Latch pc, insn and miss of w. Register gnt[w]=1 for exactly one cycle. Go to ISSUE.
  - If req == 0, remain in IDLE and ignore iu_pc_pre_oe.
- ISSUE (1 cycle):
  - iu_miss = latched miss, for this cycle only.
  - iu_pc_curr and iu_insn_curr are driven from latches, held constant from ISSUE through RESP.
  - cnt=0. Go to WAIT.
- WAIT:
  - cnt increments each cycle.
  - If iu_pc_pre_oe=1: capture iu_pc_pre into rsp_pc, rsp_timeout=0, go to RESP.
  - Else if cnt == TIMEOUT-1: rsp_pc = latched pc + 4 (mod 2^64, wraps), rsp_timeout=1, go to RESP.
  - If oe and the timeout occur in the same cycle, oe wins.
- RESP (1 cycle):
  - rsp_valid[w]=1; rsp_pc and rsp_timeout valid.
  - rr_ptr = (w+1) mod N_HART. Go to IDLE.
  - Back-to-back: the next arbitration happens in the following IDLE cycle. IDLE lasts at least 1 cycle between jobs.
- Latency: gnt appears the cycle after req is first sampled in IDLE.
  - rsp_valid appears at gnt + 2 + k cycles, where k is the number of WAIT cycles before oe.
  - Timeout response: gnt + 1 + TIMEOUT.
- iu_pc_pre_oe outside WAIT is ignored. This includes a stale result after reset or after a timeout.
- A requester deasserting req before gnt is simply not selected.
- req held after gnt is treated as a new request.
- Reset mid-operation (any state): the next cycle is IDLE with reset values. An in-flight job is dropped and gets no rsp_valid.
- Interaction of req_miss with an in-flight job: no preemption. The miss request waits for IDLE.
- Exactly one job in flight. No output is ever X after reset.

Test Plan:
- Single request: req=0001, req_pc[0]=0x1000; predictor oe after 7 cycles with pc_pre=0x1004.
  - Expected: gnt=0001 once, iu_miss=0, rsp_valid=0001 with rsp_pc=0x1004, rsp_timeout=0.
- Round-robin: req=1111 held, no misses, predictor always answers.
  - Expected: grant order is hart 0,1,2,3,0; each gnt matched by a rsp_valid to the same hart.
- Miss priority: rr_ptr=0; req=0111 with req_miss=0100.
  - Expected: first gnt=0100, iu_miss=1 for exactly one cycle, iu_pc_curr=req_pc[2].
  - Then hart 3 bit absent, so the next gnt is hart 0.
- Timeout and wrap: req_pc[1]=0xFFFF_FFFF_FFFF_FFFC; predictor never asserts oe.
  - Expected: rsp_valid=0010 at gnt+1+16, rsp_pc=0, rsp_timeout=1.
  - A late oe 3 cycles after the response produces no response.
- Timeout/oe collision: oe asserted in the same cycle cnt == TIMEOUT-1.
  - Expected: rsp_pc = iu_pc_pre, rsp_timeout=0.
- Reset mid-WAIT: assert rst for 1 cycle during WAIT.
  - Expected: next cycle state IDLE, busy=0, no rsp_valid for the dropped job, rr_ptr=0.
  - A later oe is ignored; the next request is served normally.
